// File: rtl/vram_arbiter.sv
// Purpose: arbitrates NUM_CH requesters onto one asynchronous-SRAM style VRAM port.
// Latency: grant one clk28 edge after a request is seen idle; done ACC_CYCLES edges after grant.
// Backpressure: requests are level-held until ch_done; a busy port simply delays the grant.
//
// Ports:
//   clk28, rst          - single clock, synchronous active-high reset
//   ch_req/ch_wr        - per-channel request level and direction (1 = write)
//   ch_addr/ch_wdata    - per-channel address/data, channel i at [i*W +: W]
//   ch_gnt/ch_done      - one-hot single-cycle accept / completion pulses
//   rdata               - last read data, updated together with the read's ch_done
//   va/vd_in/vd_out     - VRAM address, read data, write data
//   vd_oe, n_vrd, n_vwr - write drive enable, active-low read/write strobes
//   busy                - controller is not idle
module vram_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int AW         = 19,
   parameter int DW         = 8,
   parameter int ACC_CYCLES = 2,
   parameter int CH0_FIXED  = 1
) (
   input  logic                 clk28,
   input  logic                 rst,
   input  logic [NUM_CH-1:0]    ch_req,
   input  logic [NUM_CH-1:0]    ch_wr,
   input  logic [NUM_CH*AW-1:0] ch_addr,
   input  logic [NUM_CH*DW-1:0] ch_wdata,
   output logic [NUM_CH-1:0]    ch_gnt,
   output logic [NUM_CH-1:0]    ch_done,
   output logic [DW-1:0]        rdata,
   output logic [AW-1:0]        va,
   input  logic [DW-1:0]        vd_in,
   output logic [DW-1:0]        vd_out,
   output logic                 vd_oe,
   output logic                 n_vrd,
   output logic                 n_vwr,
   output logic                 busy
);

   localparam int              PW       = $clog2(NUM_CH);
   localparam logic [PW:0]     NCH      = (PW+1)'(NUM_CH);
   localparam logic [PW-1:0]   RR_FIRST = (CH0_FIXED != 0) ? PW'(1) : '0;
   localparam logic [2:0]      CNT_LOAD = 3'(ACC_CYCLES - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_TURN   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [NUM_CH-1:0] owner_q, owner_d;
   logic [NUM_CH-1:0] ch_gnt_q, ch_gnt_d;
   logic [NUM_CH-1:0] ch_done_q, ch_done_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic              vd_oe_q, vd_oe_d;
   logic              n_vrd_q, n_vrd_d;
   logic              n_vwr_q, n_vwr_d;

   logic              rd_complete;
   logic [NUM_CH-1:0] req_m;
   logic              win_vld;
   logic [PW-1:0]     win_idx;
   logic [NUM_CH-1:0] win_oh;
   logic [PW:0]       sum;
   logic [PW-1:0]     idx;
   logic [PW:0]       nxt;
   logic [AW-1:0]     addr_sel;
   logic [DW-1:0]     wdata_sel;
   logic              wr_sel;

   // The completing owner still holds ch_req while its done pulse is in flight,
   // so it is hidden from arbitration until the cycle after ch_done is visible.
   // Otherwise a single request would be served twice.
   assign rd_complete = (state_q == S_ACCESS) && (cnt_q == 3'd0) && !wr_q;

   always_comb begin
      req_m = ch_req & ~ch_done_q;
      if (rd_complete) begin
         req_m = req_m & ~owner_q;
      end
   end

   // Winner search: fixed ch0 first (if enabled), then a cyclic scan starting
   // at rr_ptr. The scan index is wrapped explicitly so no slice ever goes
   // past NUM_CH-1.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      sum     = '0;
      idx     = '0;
      if ((CH0_FIXED != 0) && req_m[0]) begin
         win_vld = 1'b1;
      end else begin
         for (int off = 0; off < NUM_CH; off++) begin
            sum = {1'b0, rr_ptr_q} + (PW+1)'(off);
            if (sum >= NCH) begin
               sum = sum - NCH;
            end
            idx = sum[PW-1:0];
            if (!win_vld && req_m[idx] && !((CH0_FIXED != 0) && (idx == '0))) begin
               win_vld = 1'b1;
               win_idx = idx;
            end
         end
      end
      win_oh = '0;
      if (win_vld) begin
         win_oh[win_idx] = 1'b1;
      end
   end

   always_comb begin
      addr_sel  = '0;
      wdata_sel = '0;
      wr_sel    = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (win_oh[i]) begin
            addr_sel  = ch_addr[i*AW +: AW];
            wdata_sel = ch_wdata[i*DW +: DW];
            wr_sel    = ch_wr[i];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      owner_d   = owner_q;
      ch_gnt_d  = '0;
      ch_done_d = '0;
      rdata_d   = rdata_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      nxt       = '0;

      case (state_q)
         S_IDLE: begin
         end
         S_ACCESS: begin
            if (cnt_q == 3'd0) begin
               ch_done_d = owner_q;
               if (wr_q) begin
                  state_d = S_TURN;
               end else begin
                  rdata_d = vd_in;
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_TURN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Arbitrate only when idle or at a read completion; a write always
      // passes through TURN first so the bus is released before the next access.
      if (((state_q == S_IDLE) || rd_complete) && win_vld) begin
         state_d  = S_ACCESS;
         ch_gnt_d = win_oh;
         owner_d  = win_oh;
         addr_d   = addr_sel;
         wdata_d  = wdata_sel;
         wr_d     = wr_sel;
         cnt_d    = CNT_LOAD;
         if (!((CH0_FIXED != 0) && win_oh[0])) begin
            nxt = {1'b0, win_idx} + (PW+1)'(1);
            rr_ptr_d = (nxt >= NCH) ? RR_FIRST : nxt[PW-1:0];
         end
      end

      // Strobes are registered from the next state so the pins never glitch.
      n_vrd_d = !((state_d == S_ACCESS) && !wr_d);
      n_vwr_d = !((state_d == S_ACCESS) && wr_d);
      vd_oe_d = (state_d == S_ACCESS) && wr_d;
   end

   always_ff @(posedge clk28) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= RR_FIRST;
         cnt_q     <= 3'd0;
         owner_q   <= '0;
         ch_gnt_q  <= '0;
         ch_done_q <= '0;
         rdata_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         vd_oe_q   <= 1'b0;
         n_vrd_q   <= 1'b1;
         n_vwr_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         cnt_q     <= cnt_d;
         owner_q   <= owner_d;
         ch_gnt_q  <= ch_gnt_d;
         ch_done_q <= ch_done_d;
         rdata_q   <= rdata_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wr_q      <= wr_d;
         vd_oe_q   <= vd_oe_d;
         n_vrd_q   <= n_vrd_d;
         n_vwr_q   <= n_vwr_d;
      end
   end

   assign ch_gnt  = ch_gnt_q;
   assign ch_done = ch_done_q;
   assign rdata   = rdata_q;
   assign va      = addr_q;
   assign vd_out  = wdata_q;
   assign vd_oe   = vd_oe_q;
   assign n_vrd   = n_vrd_q;
   assign n_vwr   = n_vwr_q;
   assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_vram_arbiter.sv
// Purpose: directed bench for vram_arbiter (fixed-ch0 and full round-robin instances).
// Latency: grant visible one edge after request, done ACC_CYCLES edges after grant.
// Backpressure: requests held as levels until the bench drops them.
module tb_vram_arbiter;

   logic        clk28;
   logic        rst;
   logic [7:0]  vd_in;

   logic [3:0]  req_a, wr_a, gnt_a, done_a;
   logic [75:0] addr_a;
   logic [31:0] wdata_a;
   logic [7:0]  rdata_a, vd_out_a;
   logic [18:0] va_a;
   logic        vd_oe_a, n_vrd_a, n_vwr_a, busy_a;

   logic [3:0]  req_b, wr_b, gnt_b, done_b;
   logic [75:0] addr_b;
   logic [31:0] wdata_b;
   logic [7:0]  rdata_b, vd_out_b;
   logic [18:0] va_b;
   logic        vd_oe_b, n_vrd_b, n_vwr_b, busy_b;

   int checks;
   int failures;

   vram_arbiter #(.NUM_CH(4), .AW(19), .DW(8), .ACC_CYCLES(2), .CH0_FIXED(1)) u_fix (
      .clk28(clk28), .rst(rst), .ch_req(req_a), .ch_wr(wr_a), .ch_addr(addr_a),
      .ch_wdata(wdata_a), .ch_gnt(gnt_a), .ch_done(done_a), .rdata(rdata_a), .va(va_a),
      .vd_in(vd_in), .vd_out(vd_out_a), .vd_oe(vd_oe_a), .n_vrd(n_vrd_a), .n_vwr(n_vwr_a),
      .busy(busy_a));

   vram_arbiter #(.NUM_CH(4), .AW(19), .DW(8), .ACC_CYCLES(2), .CH0_FIXED(0)) u_rr (
      .clk28(clk28), .rst(rst), .ch_req(req_b), .ch_wr(wr_b), .ch_addr(addr_b),
      .ch_wdata(wdata_b), .ch_gnt(gnt_b), .ch_done(done_b), .rdata(rdata_b), .va(va_b),
      .vd_in(vd_in), .vd_out(vd_out_b), .vd_oe(vd_oe_b), .n_vrd(n_vrd_b), .n_vwr(n_vwr_b),
      .busy(busy_b));

   initial clk28 = 1'b0;
   always #5 clk28 = ~clk28;

   task automatic tick();
      @(posedge clk28);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_a = '0; wr_a = '0; addr_a = '0; wdata_a = '0;
      req_b = '0; wr_b = '0; addr_b = '0; wdata_b = '0; vd_in = 8'h00;
      tick(); tick();
      checks++; if (gnt_a !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt_a); end
      checks++; if (done_a !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b exp=0000", done_a); end
      checks++; if (rdata_a !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata_a); end
      checks++; if (va_a !== 19'h0) begin failures++; $display("FAIL reset_va got=%h exp=0", va_a); end
      checks++; if (vd_out_a !== 8'h00) begin failures++; $display("FAIL reset_vd_out got=%h exp=00", vd_out_a); end
      checks++; if ({vd_oe_a, n_vrd_a, n_vwr_a} !== 3'b011) begin failures++; $display("FAIL reset_strobes got=%b exp=011", {vd_oe_a, n_vrd_a, n_vwr_a}); end
      checks++; if ({busy_a, busy_b} !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", {busy_a, busy_b}); end
      rst = 1'b0;
      tick();
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_idle_hold got=%b exp=0", busy_a); end
   endtask

   task automatic test_read();
      req_a = 4'b0100; wr_a = 4'b0000; addr_a[38 +: 19] = 19'h1ABCD; vd_in = 8'h5A;
      tick();
      checks++; if (gnt_a !== 4'b0100) begin failures++; $display("FAIL rd_gnt got=%b exp=0100", gnt_a); end
      checks++; if ({n_vrd_a, n_vwr_a, vd_oe_a} !== 3'b010) begin failures++; $display("FAIL rd_strobe1 got=%b exp=010", {n_vrd_a, n_vwr_a, vd_oe_a}); end
      checks++; if (va_a !== 19'h1ABCD) begin failures++; $display("FAIL rd_va got=%h exp=1abcd", va_a); end
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL rd_busy got=%b exp=1", busy_a); end
      tick();
      checks++; if ({gnt_a, done_a, n_vrd_a} !== 9'b0000_0000_0) begin failures++; $display("FAIL rd_cycle2 got=%b exp=000000000", {gnt_a, done_a, n_vrd_a}); end
      tick();
      checks++; if (done_a !== 4'b0100) begin failures++; $display("FAIL rd_done got=%b exp=0100", done_a); end
      checks++; if (rdata_a !== 8'h5A) begin failures++; $display("FAIL rd_rdata got=%h exp=5a", rdata_a); end
      checks++; if ({n_vrd_a, busy_a} !== 2'b10) begin failures++; $display("FAIL rd_end got=%b exp=10", {n_vrd_a, busy_a}); end
      req_a = 4'b0000; vd_in = 8'h00;
      tick();
      checks++; if ({gnt_a, done_a, busy_a} !== 9'b0) begin failures++; $display("FAIL rd_idle got=%b exp=000000000", {gnt_a, done_a, busy_a}); end
      checks++; if (rdata_a !== 8'h5A) begin failures++; $display("FAIL rd_rdata_hold got=%h exp=5a", rdata_a); end
   endtask

   task automatic test_write();
      req_a = 4'b0010; wr_a = 4'b0010; addr_a[19 +: 19] = 19'h00100; wdata_a[8 +: 8] = 8'h33;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++; if ({vd_oe_a, n_vwr_a, n_vrd_a} !== 3'b101) begin failures++; $display("FAIL wr_strobe c=%0d got=%b exp=101", c, {vd_oe_a, n_vwr_a, n_vrd_a}); end
         checks++; if ({va_a, vd_out_a} !== {19'h00100, 8'h33}) begin failures++; $display("FAIL wr_bus c=%0d got=%h/%h exp=00100/33", c, va_a, vd_out_a); end
      end
      tick();
      checks++; if (done_a !== 4'b0010) begin failures++; $display("FAIL wr_done got=%b exp=0010", done_a); end
      checks++; if ({vd_oe_a, n_vwr_a, busy_a} !== 3'b011) begin failures++; $display("FAIL wr_turn got=%b exp=011", {vd_oe_a, n_vwr_a, busy_a}); end
      req_a = 4'b0000; wr_a = 4'b0000;
      tick();
      checks++; if ({busy_a, done_a, gnt_a} !== 9'b0) begin failures++; $display("FAIL wr_idle got=%b exp=000000000", {busy_a, done_a, gnt_a}); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_seq [0:6];
      exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0000; exp_seq[2] = 4'b0100; exp_seq[3] = 4'b0000;
      exp_seq[4] = 4'b1000; exp_seq[5] = 4'b0000; exp_seq[6] = 4'b0010;
      do_reset();
      req_a = 4'b1110; wr_a = 4'b0000;
      for (int c = 0; c < 7; c++) begin
         tick();
         checks++; if (gnt_a !== exp_seq[c]) begin failures++; $display("FAIL b2b_gnt c=%0d got=%b exp=%b", c, gnt_a, exp_seq[c]); end
         checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL b2b_busy c=%0d got=%b exp=1", c, busy_a); end
      end
      req_a = 4'b0000;
      for (int i = 0; i < 20 && busy_a; i++) tick();
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", busy_a); end
   endtask

   task automatic test_ch0_priority();
      do_reset();
      req_a = 4'b1000; wr_a = 4'b0000;
      tick();
      checks++; if (gnt_a !== 4'b1000) begin failures++; $display("FAIL pri_gnt3 got=%b exp=1000", gnt_a); end
      req_a = 4'b1111;
      tick();
      checks++; if ({gnt_a, n_vrd_a, busy_a} !== 6'b0000_0_1) begin failures++; $display("FAIL pri_no_abort got=%b exp=000001", {gnt_a, n_vrd_a, busy_a}); end
      tick();
      checks++; if (done_a !== 4'b1000) begin failures++; $display("FAIL pri_done3 got=%b exp=1000", done_a); end
      checks++; if (gnt_a !== 4'b0001) begin failures++; $display("FAIL pri_gnt0 got=%b exp=0001", gnt_a); end
      req_a = 4'b0111;
      tick(); tick();
      checks++; if ({done_a, gnt_a} !== 8'b0001_0010) begin failures++; $display("FAIL pri_after0 got=%b exp=00010010", {done_a, gnt_a}); end
      req_a = 4'b0110;
      tick(); tick();
      checks++; if ({done_a, gnt_a} !== 8'b0010_0100) begin failures++; $display("FAIL pri_next got=%b exp=00100100", {done_a, gnt_a}); end
      req_a = 4'b0000;
      for (int i = 0; i < 20 && busy_a; i++) tick();
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL pri_drain got=%b exp=0", busy_a); end
   endtask

   task automatic test_rr_all();
      logic [3:0] exp_seq [0:6];
      exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0000; exp_seq[2] = 4'b0010; exp_seq[3] = 4'b0000;
      exp_seq[4] = 4'b0100; exp_seq[5] = 4'b0000; exp_seq[6] = 4'b1000;
      do_reset();
      req_b = 4'b1111; wr_b = 4'b0000;
      for (int c = 0; c < 7; c++) begin
         tick();
         checks++; if (gnt_b !== exp_seq[c]) begin failures++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt_b, exp_seq[c]); end
      end
      req_b = 4'b0000;
      for (int i = 0; i < 20 && busy_b; i++) tick();
      checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b exp=0", busy_b); end
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      req_a = 4'b0010; wr_a = 4'b0010; addr_a[19 +: 19] = 19'h00200; wdata_a[8 +: 8] = 8'hC3;
      tick();
      checks++; if ({n_vwr_a, vd_oe_a} !== 2'b01) begin failures++; $display("FAIL rst_mid_pre got=%b exp=01", {n_vwr_a, vd_oe_a}); end
      rst = 1'b1; req_a = 4'b0000; wr_a = 4'b0000;
      tick();
      checks++; if ({n_vwr_a, vd_oe_a, busy_a} !== 3'b100) begin failures++; $display("FAIL rst_mid_strobe got=%b exp=100", {n_vwr_a, vd_oe_a, busy_a}); end
      checks++; if (done_a !== 4'b0000) begin failures++; $display("FAIL rst_mid_done got=%b exp=0000", done_a); end
      rst = 1'b0;
      tick(); tick();
      checks++; if ({done_a, busy_a, n_vwr_a} !== 6'b0000_0_1) begin failures++; $display("FAIL rst_mid_after got=%b exp=000001", {done_a, busy_a, n_vwr_a}); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_ch0_priority();
      test_rr_all();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requester channels, legal range 2..8.
REQ-002 SHALL have parameter AW, default 19: VRAM address width.
REQ-003 SHALL have parameter DW, default 8: data width.
REQ-004 SHALL have parameter ACC_CYCLES, default 2: strobe length per access in clk28 cycles, legal range 1..7.
REQ-005 SHALL have parameter CH0_FIXED, default 1: when 1, ch0 has fixed top priority; when 0, all channels share round-robin.
REQ-006 SHALL have port clk28  in  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port ch_req  in  NUM_CH  per-channel access request, level, held until ch_done.
REQ-009 SHALL have port ch_wr  in  NUM_CH  per-channel direction, 1=write.
REQ-010 SHALL have port ch_addr  in  NUM_CH*AW  per-channel address; channel i occupies bits [i*AW +: AW].
REQ-011 SHALL have port ch_wdata  in  NUM_CH*DW  per-channel write data, packed the same way as ch_addr.
REQ-012 SHALL have port ch_gnt  out  NUM_CH  one-hot, one-cycle pulse when a channel's request is accepted.
REQ-013 SHALL have port ch_done  out  NUM_CH  one-hot, one-cycle pulse on access completion.
REQ-014 SHALL have port rdata  out  DW  last read data; valid from the ch_done cycle until the next read completes.
REQ-015 SHALL have port va  out  AW  VRAM address.
REQ-016 SHALL have port vd_in  in  DW  VRAM read data.
REQ-017 SHALL have port vd_out  out  DW  VRAM write data.
REQ-018 SHALL have port vd_oe  out  1  write data drive enable.
REQ-019 SHALL have port n_vrd  out  1  active-low read strobe.
REQ-020 SHALL have port n_vwr  out  1  active-low write strobe.
REQ-021 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-022 SHALL implement the FSM states IDLE, ACCESS and TURN.
REQ-023 In IDLE with any ch_req set, SHALL in the same cycle select a winner, pulse its ch_gnt, latch its addr/wr/wdata, load the cycle counter with ACC_CYCLES-1, and enter ACCESS.
REQ-024 Winner selection SHALL be: ch0 if CH0_FIXED=1 and ch_req[0]=1; otherwise the first requesting channel at or after rr_ptr, searched cyclically over the round-robin set.
REQ-025 The round-robin set SHALL be 1..NUM_CH-1 when CH0_FIXED=1, and 0..NUM_CH-1 when CH0_FIXED=0.
REQ-026 After granting a round-robin channel k, rr_ptr SHALL advance to the next member after k, wrapping; a fixed ch0 grant SHALL leave rr_ptr unchanged.
REQ-027 In ACCESS, va SHALL equal the latched address, and n_vrd (read) or n_vwr (write) SHALL be low for exactly ACC_CYCLES cycles.
REQ-028 For a write, vd_out SHALL equal the latched data, and vd_oe SHALL be high throughout ACCESS.
REQ-029 In the last ACCESS cycle (counter=0), SHALL pulse ch_done of the owner and, for a read, capture vd_in into rdata at that edge.
REQ-030 On completion of a read, SHALL arbitrate immediately and go back-to-back into ACCESS if any request is pending, else go to IDLE.
REQ-031 On completion of a write, SHALL enter TURN for 1 cycle, with both strobes high and vd_oe low, then go to IDLE.
REQ-032 Arbitration SHALL occur only in IDLE or at read completion; a ch0 request SHALL never abort an ongoing access.
REQ-033 A request deasserted before its grant SHALL be ignored; a request still high after ch_done SHALL be treated as a new request.
REQ-034 ch_req changes after grant SHALL NOT affect the latched access.
REQ-035 Outside ACCESS, SHALL hold n_vrd=n_vwr=1 and vd_oe=0.
REQ-036 Round-robin latency SHALL be bounded: a held request on a round-robin channel is granted within (size of round-robin set) round-robin grants.
REQ-037 Indices SHALL wrap modulo NUM_CH without using out-of-range packed slices.

Reset
REQ-038 While rst=1 at a clock edge, SHALL set: state=IDLE, rr_ptr=first member of the round-robin set, counter=0, ch_gnt=0, ch_done=0, rdata=0, va=0, vd_out=0, vd_oe=0, n_vrd=1, n_vwr=1, busy=0.
REQ-039 Reset asserted mid-access SHALL abort the access with no ch_done, and strobes SHALL be inactive from the next edge.

Verification
REQ-040 SHALL verify: NUM_CH=4, ACC_CYCLES=2, ch2 reads 0x1ABCD with vd_in=0x5A -> ch_gnt[2] pulse, n_vrd low 2 cycles, ch_done[2] pulse, rdata=0x5A, then IDLE.
REQ-041 SHALL verify: ch1 writes 0x33 to 0x00100 -> vd_oe=1 and n_vwr low 2 cycles with va=0x00100, vd_out=0x33, then 1 TURN cycle with vd_oe=0, then IDLE.
REQ-042 SHALL verify: ch1..ch3 requesting continuously with reads -> grants in order 1,2,3,1 back-to-back, with no IDLE cycle between them.
REQ-043 SHALL verify: ch0 asserted during ch3's access with CH0_FIXED=1 -> ch3 completes, then ch0 is granted next ahead of ch1/ch2, and rr_ptr is unchanged.
REQ-044 SHALL verify: CH0_FIXED=0, all 4 channels requesting -> grants rotate 0,1,2,3.
REQ-045 SHALL verify: rst pulsed in the first ACCESS cycle of a write -> n_vwr=1 and vd_oe=0 next edge, no ch_done, busy=0.
